// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, datapath widths
// and controller FSM encoding.
package alu_pkg;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;

  typedef enum logic [OP_W-1:0] {
    OP_PASSA = 3'b000,
    OP_ADD   = 3'b001,
    OP_SUB   = 3'b010,
    OP_AND   = 3'b011,
    OP_XOR   = 3'b100,
    OP_ABS   = 3'b101,
    OP_CAL   = 3'b110,
    OP_CND   = 3'b111
  } alu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick,
// search starts one past the last granted slot.
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   last,
  output logic [NREQ-1:0] gnt
);

  // scan farthest-first so the nearest hit wins
  always_comb begin
    gnt = '0;
    for (int i = NREQ; i >= 1; i--) begin
      for (int j = 0; j < NREQ; j++) begin
        if ((int'(last) + i) % NREQ == j
            && req[j]) begin
          gnt    = '0;
          gnt[j] = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// alu_share_ctrl: shares one registered ALU
// between NREQ requesters, round-robin.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int ALU_LAT = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [OP_W*NREQ-1:0]   req_opcode,
  input  logic [DATA_W*NREQ-1:0] req_data,
  input  logic [DATA_W*NREQ-1:0] req_accum,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_result,
  output logic                   rsp_zero,
  output logic                   busy,
  output logic [OP_W-1:0]        alu_opcode,
  output logic [DATA_W-1:0]      alu_data,
  output logic [DATA_W-1:0]      alu_accum,
  input  logic [DATA_W-1:0]      alu_out,
  input  logic                   alu_zero
);

  localparam int PW = $clog2(NREQ);

  state_t            state;
  logic [1:0]        cnt;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     cur_idx;
  logic [NREQ-1:0]   cur_gnt;
  logic [NREQ-1:0]   win;
  logic [PW-1:0]     sel_idx;
  logic [OP_W-1:0]   sel_op;
  logic [DATA_W-1:0] sel_data;
  logic [DATA_W-1:0] sel_accum;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_arb (
    .req  (req),
    .last (ptr),
    .gnt  (win)
  );

  // one-hot AND-OR operand mux
  always_comb begin
    sel_idx   = '0;
    sel_op    = '0;
    sel_data  = '0;
    sel_accum = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (win[k]) begin
        sel_idx   = PW'(k);
        sel_op    = req_opcode[k*OP_W +: OP_W];
        sel_data  = req_data[k*DATA_W +: DATA_W];
        sel_accum = req_accum[k*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ptr        <= PW'(NREQ - 1);
      cur_idx    <= '0;
      cur_gnt    <= '0;
      gnt        <= '0;
      rsp_valid  <= '0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      busy       <= 1'b0;
      alu_opcode <= OP_PASSA;
      alu_data   <= '0;
      alu_accum  <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      unique case (state)
        S_IDLE: begin
          if (|req) begin
            gnt        <= win;
            cur_gnt    <= win;
            cur_idx    <= sel_idx;
            alu_opcode <= sel_op;
            alu_data   <= sel_data;
            alu_accum  <= sel_accum;
            cnt        <= '0;
            busy       <= 1'b1;
            state      <= S_EXEC;
          end
        end
        S_EXEC: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'(ALU_LAT - 1)) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          rsp_result <= alu_out;
          rsp_zero   <= alu_zero;
          rsp_valid  <= cur_gnt;
          ptr        <= cur_idx;
          busy       <= 1'b0;
          state      <= S_IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
